logic_op_pipe: RTL and testbench
================================

Name: logic_op_pipe

Overview:
Parametrised registered bitwise logic unit; successor to the single-bit registered inverter.
- Applies one of four bitwise ops (NOT/AND/OR/XOR) to WIDTH-bit operands.
- Carries the result through a DEPTH-stage register pipeline with valid/ready handshakes on both sides.
- Used as a generic registered datapath element and as a handshake/pipeline training block in the lab series.

Parameters:
WIDTH, 8, operand/result width in bits (>=1)
DEPTH, 2, number of register stages = latency in cycles (>=1)
RST_VAL, {WIDTH{1'b0}}, reset value of every data stage register and of out

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input transfer request
in_ready  output  1  block can accept input this cycle
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B (ignored for NOT)
op  input  2  operation select, sampled with in_a/in_b
out_valid  output  1  out holds a valid result
out_ready  input  1  downstream accepts result
out  output  WIDTH  result (last stage data register)
busy  output  1  OR of all stage valid bits

Behaviour:
- Reset: one clock, clk; rst_n is asynchronous, active-low.
  - While rst_n=0, independent of clk: all stage valid bits=0, all data regs=RST_VAL.
  - Hence out_valid=0, out=RST_VAL, busy=0, in_ready=1.
  - Reset asserted mid-operation discards all in-flight results; nothing emerges after release.
  - Deassertion takes effect at the first rising edge with rst_n=1.
- op encoding, computed combinationally at input, captured into stage 0:
  - 00: ~in_a
  - 01: in_a & in_b
  - 10: in_a | in_b
  - 11: in_a ^ in_b
  - No width growth; result is exactly WIDTH bits.
- Advance enable: en = ~out_valid | out_ready.
  - The whole pipeline moves together (global stall); bubbles are not compressed.
  - in_ready = en (combinational from out_valid/out_ready; no combinational path from in_valid).
- Input transfer: in_valid & in_ready at a rising edge. Output transfer: out_valid & out_ready at a rising edge.
- On each edge with en=1:
  - valid[0] <= in_valid; valid[i] <= valid[i-1].
  - Data reg i loads from its upstream only when the upstream valid is 1; otherwise it holds.
- On each edge with en=0: all valid and data regs hold.
- Latency: a result captured at edge k appears with out_valid=1 after edge k+DEPTH-1 when unstalled; DEPTH=1 gives one-cycle latency.
- Throughput: one result per cycle when out_ready=1 continuously.
- Data integrity: results leave in input order, none lost or duplicated, under any out_ready pattern.
- in_valid=0 and out_ready=0: stable, outputs unchanged.
- out holds the last valid result while out_valid=0. The value is not guaranteed meaningful; the bench checks out only when out_valid=1.
- Inputs sampled only on an input transfer; changes to in_a/in_b/op while in_ready=0 have no effect.

Optional Feature:
LOGIC_OP_PIPE_CNT_EN
- Defined:
  - Adds output port xfer_cnt [15:0].
  - Increments by 1 on every output transfer.
  - Wraps 16'hFFFF -> 16'h0000.
  - Cleared asynchronously by rst_n.
- Undefined: port and counter logic absent; all other behaviour identical.

Test Plan:
1. Reset: WIDTH=8, DEPTH=2, RST_VAL=0; drive rst_n=0 at t=3ns between edges -> out_valid=0, out=8'h00, busy=0, in_ready=1 before next edge; release at negedge -> idle.
2. NOT latency: in_a=8'hA5, op=00, in_valid for one cycle, out_ready=1 -> out_valid=1 for exactly one cycle, one edge after capture, out=8'h5A; busy high for 2 cycles.
3. Back-to-back ops: a=8'hF0, b=8'h3C, op=01,10,11 on consecutive cycles, out_ready=1 -> outputs 8'h30, 8'hFC, 8'hCC on consecutive cycles.
4. Stall: out_ready=0, send 3 items (8'h01,8'h02,8'h03 as NOT) -> in_ready=0 while out_valid=1, out holds 8'hFE; raise out_ready -> 8'hFE, 8'hFD, 8'hFC in order, none duplicated.
5. Reset mid-flight: 2 items in pipeline, pulse rst_n low for 2ns between edges -> valid bits clear at once, no out_valid after release; with LOGIC_OP_PIPE_CNT_EN, xfer_cnt=0.
6. Minimal instance: WIDTH=1, DEPTH=1, out_ready=1 -> in_a=1, op=00 gives out=0 after the capturing edge. With LOGIC_OP_PIPE_CNT_EN, preload via 65536 transfers -> xfer_cnt wraps to 0.

Source files
------------

// File: rtl/logic_op_pipe.sv
// Registered bitwise logic unit (NOT/AND/OR/XOR) feeding a DEPTH-stage valid/ready pipeline.
// Optional LOGIC_OP_PIPE_CNT_EN adds a 16-bit output-transfer counter port xfer_cnt.
module logic_op_pipe #(
    parameter int                WIDTH   = 8,
    parameter int                DEPTH   = 2,
    parameter logic [WIDTH-1:0]  RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             busy
`ifdef LOGIC_OP_PIPE_CNT_EN
    ,
    output logic [15:0]      xfer_cnt
`endif
);

    logic             w_en;
    logic [WIDTH-1:0] w_res;
    logic [DEPTH-1:0] w_valid;
    logic [WIDTH-1:0] w_data [DEPTH];

    always_comb begin
        w_res = ~in_a;
        case (op)
            2'b00: w_res = ~in_a;
            2'b01: w_res = in_a & in_b;
            2'b10: w_res = in_a | in_b;
            2'b11: w_res = in_a ^ in_b;
            default: w_res = ~in_a;
        endcase
    end

    // Global stall: every stage advances together whenever the last stage can drain.
    assign w_en = ~w_valid[DEPTH-1] | out_ready;

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        logic             r_v;
        logic [WIDTH-1:0] r_d;
        logic             w_up_v;
        logic [WIDTH-1:0] w_up_d;

        if (g == 0) begin : g_first
            assign w_up_v = in_valid;
            assign w_up_d = w_res;
        end else begin : g_next
            assign w_up_v = w_valid[g-1];
            assign w_up_d = w_data[g-1];
        end

        // Data only follows real items, so bubbles leave the previous value in place.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_v <= 1'b0;
                r_d <= RST_VAL;
            end else if (w_en) begin
                r_v <= w_up_v;
                if (w_up_v) begin
                    r_d <= w_up_d;
                end
            end
        end

        assign w_valid[g] = r_v;
        assign w_data[g]  = r_d;
    end

    assign in_ready  = w_en;
    assign out_valid = w_valid[DEPTH-1];
    assign out       = w_data[DEPTH-1];
    assign busy      = |w_valid;

`ifdef LOGIC_OP_PIPE_CNT_EN
    logic [15:0] r_xfer_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xfer_cnt <= 16'h0000;
        end else if (w_valid[DEPTH-1] && out_ready) begin
            r_xfer_cnt <= r_xfer_cnt + 16'd1;
        end
    end

    assign xfer_cnt = r_xfer_cnt;
`endif

endmodule

// File: tb/tb_logic_op_pipe.sv
// Scoreboard bench for logic_op_pipe: expected results queued at input transfer, popped by an output monitor.
// A second WIDTH=1/DEPTH=1 instance covers the minimal configuration and counter wrap.
module tb_logic_op_pipe;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic [1:0] op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out;
    logic       busy;

    logic       m_in_valid;
    logic       m_in_ready;
    logic [0:0] m_a;
    logic [0:0] m_b;
    logic [1:0] m_op;
    logic       m_out_valid;
    logic       m_out_ready;
    logic [0:0] m_out;
    logic       m_busy;

`ifdef LOGIC_OP_PIPE_CNT_EN
    logic [15:0] xfer_cnt;
    logic [15:0] m_xfer_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q [$];

    logic_op_pipe #(.WIDTH(8), .DEPTH(2), .RST_VAL(8'h00)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .op(op), .out_valid(out_valid),
        .out_ready(out_ready), .out(out), .busy(busy)
`ifdef LOGIC_OP_PIPE_CNT_EN
        , .xfer_cnt(xfer_cnt)
`endif
    );

    logic_op_pipe #(.WIDTH(1), .DEPTH(1), .RST_VAL(1'b0)) u_min (
        .clk(clk), .rst_n(rst_n), .in_valid(m_in_valid), .in_ready(m_in_ready),
        .in_a(m_a), .in_b(m_b), .op(m_op), .out_valid(m_out_valid),
        .out_ready(m_out_ready), .out(m_out), .busy(m_busy)
`ifdef LOGIC_OP_PIPE_CNT_EN
        , .xfer_cnt(m_xfer_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Output monitor: a transfer happens at the next rising edge when valid & ready are seen here.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got %0h expected none at %0t", out, $time);
                end else begin
                    chk("out_data", {24'h0, out}, {24'h0, exp_q.pop_front()});
                end
            end
        end
    end

    // Drives one item and waits (bounded) for the input transfer; leaves in_valid high.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] o,
                        input logic [7:0] exp);
        logic ok;
        int   n;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        op       = o;
        n        = 0;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 50);
        if (ok) begin
            exp_q.push_back(exp);
        end else begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready 0 expected 1 at %0t", $time);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int n_xfer;
        rst_n       = 1'b1;
        in_valid    = 1'b0;
        in_a        = 8'h00;
        in_b        = 8'h00;
        op          = 2'b00;
        out_ready   = 1'b0;
        m_in_valid  = 1'b0;
        m_a         = 1'b0;
        m_b         = 1'b0;
        m_op        = 2'b00;
        m_out_ready = 1'b0;

        // 1. asynchronous reset between edges
        #3 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_out", {24'h0, out}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cycles(2);
        chk("idle_busy", {31'h0, busy}, 32'h0);

        // 2. NOT latency
        out_ready = 1'b1;
        send(8'hA5, 8'h00, 2'b00, 8'h5A);
        in_valid = 1'b0;
        chk("lat_ov_k", {31'h0, out_valid}, 32'h0);
        chk("lat_busy_k", {31'h0, busy}, 32'h1);
        cycles(1);
        chk("lat_ov_k1", {31'h0, out_valid}, 32'h1);
        chk("lat_busy_k1", {31'h0, busy}, 32'h1);
        chk("lat_out_k1", {24'h0, out}, 32'h5A);
        cycles(1);
        chk("lat_ov_k2", {31'h0, out_valid}, 32'h0);
        chk("lat_busy_k2", {31'h0, busy}, 32'h0);

        // 3. back-to-back AND/OR/XOR
        send(8'hF0, 8'h3C, 2'b01, 8'h30);
        send(8'hF0, 8'h3C, 2'b10, 8'hFC);
        send(8'hF0, 8'h3C, 2'b11, 8'hCC);
        in_valid = 1'b0;
        cycles(4);
        chk("b2b_drained", exp_q.size(), 32'h0);

        // 4. stall with three NOT items
        out_ready = 1'b0;
        fork
            begin
                send(8'h01, 8'h00, 2'b00, 8'hFE);
                send(8'h02, 8'h00, 2'b00, 8'hFD);
                send(8'h03, 8'h00, 2'b00, 8'hFC);
                in_valid = 1'b0;
            end
            begin
                cycles(5);
                chk("stall_in_ready", {31'h0, in_ready}, 32'h0);
                chk("stall_ov", {31'h0, out_valid}, 32'h1);
                chk("stall_out", {24'h0, out}, 32'hFE);
                out_ready = 1'b1;
            end
        join
        cycles(5);
        chk("stall_drained", exp_q.size(), 32'h0);
        chk("stall_idle", {31'h0, out_valid}, 32'h0);

        // 5. reset while two items are in flight
        out_ready = 1'b0;
        send(8'h10, 8'h00, 2'b00, 8'hEF);
        send(8'h20, 8'h00, 2'b00, 8'hDF);
        in_valid = 1'b0;
        cycles(1);
        chk("mid_busy_pre", {31'h0, busy}, 32'h1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_ov", {31'h0, out_valid}, 32'h0);
        chk("mid_busy", {31'h0, busy}, 32'h0);
        chk("mid_in_ready", {31'h0, in_ready}, 32'h1);
`ifdef LOGIC_OP_PIPE_CNT_EN
        chk("mid_xfer_cnt", {16'h0, xfer_cnt}, 32'h0);
`endif
        #1 rst_n = 1'b1;
        exp_q.delete();
        out_ready = 1'b1;
        cycles(4);
        chk("mid_after_ov", {31'h0, out_valid}, 32'h0);
        chk("mid_after_busy", {31'h0, busy}, 32'h0);

        // 6. minimal WIDTH=1 DEPTH=1 instance
        m_out_ready = 1'b1;
        m_in_valid  = 1'b1;
        m_a         = 1'b1;
        m_op        = 2'b00;
        cycles(1);
        m_in_valid  = 1'b0;
        chk("min_ov", {31'h0, m_out_valid}, 32'h1);
        chk("min_out", {31'h0, m_out}, 32'h0);
        cycles(1);
        chk("min_ov_after", {31'h0, m_out_valid}, 32'h0);
`ifdef LOGIC_OP_PIPE_CNT_EN
        chk("min_cnt_one", {16'h0, m_xfer_cnt}, 32'h1);
        n_xfer     = 1;
        m_in_valid = 1'b1;
        m_a        = 1'b0;
        for (int i = 0; i < 70000 && n_xfer < 65536; i++) begin
            @(negedge clk);
            if (m_out_valid && m_out_ready) n_xfer++;
            @(posedge clk);
            #1;
            if (n_xfer == 65535) chk("cnt_ffff", {16'h0, m_xfer_cnt}, 32'hFFFF);
        end
        m_in_valid = 1'b0;
        chk("cnt_n_reached", n_xfer, 32'd65536);
        chk("cnt_wrap", {16'h0, m_xfer_cnt}, 32'h0);
`endif

        chk("final_queue_empty", exp_q.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
